mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter onto a single memory port: writes complete in one cycle,
// reads hold the port for a second cycle while the read data returns.
module mem_port_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [15:0] conflict_cnt
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RD_WAIT = 1'b1;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [0:0]    state_q, state_d;
  logic          last_win_q, last_win_d;
  logic          owner_q, owner_d;
  logic          rvalid_q, rvalid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0_c, gnt1_c, any_gnt_c, win_we_c;

  // Arbitration, next-state and conflict counting
  always_comb begin
    state_d    = state_q;
    last_win_d = last_win_q;
    owner_d    = owner_q;
    rvalid_d   = 1'b0;
    cnt_d      = cnt_q;
    gnt0_c     = 1'b0;
    gnt1_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst) begin
          if (m0_req && m1_req) begin
            if (RR_EN && (last_win_q == M0)) gnt1_c = 1'b1;
            else                             gnt0_c = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          end else begin
            gnt0_c = m0_req;
            gnt1_c = m1_req;
          end
        end
      end
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    any_gnt_c = gnt0_c | gnt1_c;
    win_we_c  = gnt1_c ? m1_we : m0_we;

    if (any_gnt_c) begin
      last_win_d = gnt1_c;
      if (!win_we_c) begin
        state_d  = RD_WAIT;
        owner_d  = gnt1_c;
        rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_win_q <= M1;
      owner_q    <= M0;
      rvalid_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_win_q <= last_win_d;
      owner_q    <= owner_d;
      rvalid_q   <= rvalid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m0_gnt    = gnt0_c;
  assign m1_gnt    = gnt1_c;
  assign mem_write = any_gnt_c & win_we_c;
  assign mem_read  = any_gnt_c & ~win_we_c;
  assign mem_addr  = gnt1_c ? m1_addr  : (gnt0_c ? m0_addr  : '0);
  assign mem_wdata = gnt1_c ? m1_wdata : (gnt0_c ? m0_wdata : '0);

  // Read return is steered by the owner captured at grant time
  assign m0_rvalid = rvalid_q & (owner_q == M0);
  assign m1_rvalid = rvalid_q & (owner_q == M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : DW'(0);
  assign m1_rdata  = m1_rvalid ? mem_rdata : DW'(0);

  assign busy         = (state_q == RD_WAIT);
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin and a fixed-priority
// instance share master stimulus; read data is checked through a scoreboard.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;

  logic        rr_m0_gnt, rr_m1_gnt, rr_m0_rvalid, rr_m1_rvalid;
  logic [31:0] rr_m0_rdata, rr_m1_rdata;
  logic        rr_mem_write, rr_mem_read, rr_busy;
  logic [31:0] rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
  logic [15:0] rr_cnt;

  logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_mem_write, fp_mem_read, fp_busy;
  logic [31:0] fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
  logic [15:0] fp_cnt;

  logic [31:0] rr_mem  [256];
  logic [31:0] ref_mem [256];
  logic [32:0] sb_q [$];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(rr_m0_gnt), .m1_gnt(rr_m1_gnt),
    .m0_rvalid(rr_m0_rvalid), .m1_rvalid(rr_m1_rvalid),
    .m0_rdata(rr_m0_rdata), .m1_rdata(rr_m1_rdata),
    .mem_write(rr_mem_write), .mem_read(rr_mem_read),
    .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata),
    .busy(rr_busy), .conflict_cnt(rr_cnt)
  );

  mem_port_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(fp_m0_gnt), .m1_gnt(fp_m1_gnt),
    .m0_rvalid(fp_m0_rvalid), .m1_rvalid(fp_m1_rvalid),
    .m0_rdata(fp_m0_rdata), .m1_rdata(fp_m1_rdata),
    .mem_write(fp_mem_write), .mem_read(fp_mem_read),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata),
    .busy(fp_busy), .conflict_cnt(fp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the round-robin instance: one-cycle read latency
  always @(posedge clk) begin
    if (rr_mem_write) rr_mem[rr_mem_addr[7:0]] <= rr_mem_wdata;
    if (rr_mem_read)  rr_mem_rdata <= rr_mem[rr_mem_addr[7:0]];
  end
  assign fp_mem_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  // Holds reset for two cycles with both masters requesting; returns just after release
  task automatic do_reset();
    drive(1'b1, 1'b1, 32'h10, 32'h1, 1'b1, 1'b0, 32'h13, 32'h2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_m0_gnt", 32'(rr_m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(rr_m1_gnt | fp_m1_gnt | fp_m0_gnt), 32'd0);
    chk("rst_strobes", 32'({rr_mem_write, rr_mem_read, fp_mem_write, fp_mem_read}), 32'd0);
    chk("rst_rdata", rr_m0_rdata | rr_m1_rdata, 32'd0);
    chk("rst_cnt", 32'(rr_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Read-return monitor: every rvalid must match the oldest queued expectation
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && (rr_m0_rvalid || rr_m1_rvalid)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_rvalid", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("rv_owner", 32'({rr_m1_rvalid, rr_m0_rvalid}), e[32] ? 32'd2 : 32'd1);
        chk("rv_rdata", e[32] ? rr_m1_rdata : rr_m0_rdata, e[31:0]);
        chk("rv_other_rdata", e[32] ? rr_m0_rdata : rr_m1_rdata, 32'd0);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write then read back on M0, first grant right after reset
    do_reset();
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    ref_mem[8'h10] = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_m0_gnt", 32'(rr_m0_gnt), 32'd1);
    chk("wr_mem_write", 32'({rr_mem_write, rr_mem_read}), 32'd2);
    chk("wr_mem_addr", rr_mem_addr, 32'h10);
    chk("wr_mem_wdata", rr_mem_wdata, 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    sb_q.push_back({1'b0, ref_mem[8'h10]});
    @(negedge clk);
    chk("rd_m0_gnt", 32'(rr_m0_gnt), 32'd1);
    chk("rd_mem_read", 32'({rr_mem_write, rr_mem_read}), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rd_busy", 32'(rr_busy), 32'd1);
    chk("rd_m0_rvalid", 32'(rr_m0_rvalid), 32'd1);
    tick();
    @(negedge clk);
    chk("rd_rvalid_pulse", 32'({rr_m0_rvalid, rr_busy}), 32'd0);

    // Unaligned address goes out unmodified
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h13, 32'h12345678);
    ref_mem[8'h13] = 32'h12345678;
    @(negedge clk);
    chk("m1_wr_gnt", 32'(rr_m1_gnt), 32'd1);
    chk("m1_wr_addr", rr_mem_addr, 32'h13);
    tick();

    // Round-robin reads, both masters every cycle
    do_reset();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0);
    for (int i = 0; i < 8; i++) begin
      logic e0, e1;
      e0 = (i % 4) == 0;
      e1 = (i % 4) == 2;
      if (e0) sb_q.push_back({1'b0, ref_mem[8'h10]});
      if (e1) sb_q.push_back({1'b1, ref_mem[8'h13]});
      @(negedge clk);
      chk($sformatf("rr_gnt_c%0d", i), 32'({rr_m1_gnt, rr_m0_gnt}), 32'({e1, e0}));
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rr_conflict_cnt", 32'(rr_cnt), 32'd4);

    // Fixed priority, both masters writing continuously
    do_reset();
    drive(1'b1, 1'b1, 32'h20, 32'hA0A0A0A0, 1'b1, 1'b1, 32'h24, 32'hB0B0B0B0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("fp_gnt_c%0d", i), 32'({fp_m1_gnt, fp_m0_gnt}), 32'd1);
      chk($sformatf("fp_addr_c%0d", i), fp_mem_addr, 32'h20);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("fp_conflict_cnt", 32'(fp_cnt), 32'd5);

    // Reset during an M1 read wait discards the read
    do_reset();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0);
    sb_q.push_back({1'b0, ref_mem[8'h10]});
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0);
    tick();
    @(negedge clk);
    chk("rst_rd_m1_gnt", 32'(rr_m1_gnt), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rd_busy", 32'(rr_busy), 32'd0);
    chk("rst_rd_cnt", 32'(rr_cnt), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_rd_no_rvalid_%0d", i), 32'({rr_m1_rvalid, rr_busy}), 32'd0);
      tick();
    end

    // Saturation of the conflict counter
    do_reset();
    drive(1'b1, 1'b1, 32'h20, 32'h1, 1'b1, 1'b1, 32'h24, 32'h2);
    repeat (65534) tick();
    @(negedge clk);
    chk("sat_cnt_fffe", 32'(fp_cnt), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("sat_cnt_%0d", i), 32'(fp_cnt), 32'h0000FFFF);
    end
    tick();

    // Request arriving in RD_WAIT is held off one cycle; dropped request has no effect
    do_reset();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    sb_q.push_back({1'b0, ref_mem[8'h10]});
    @(negedge clk);
    chk("ho_m0_gnt_n", 32'(rr_m0_gnt), 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h30, 32'hC0FFEE00);
    @(negedge clk);
    chk("ho_m1_gnt_n1", 32'(rr_m1_gnt), 32'd0);
    chk("ho_m0_rvalid_n1", 32'(rr_m0_rvalid), 32'd1);
    chk("ho_no_write_n1", 32'(rr_mem_write), 32'd0);
    tick();
    ref_mem[8'h30] = 32'hC0FFEE00;
    @(negedge clk);
    chk("ho_m1_gnt_n2", 32'(rr_m1_gnt), 32'd1);
    chk("ho_addr_n2", rr_mem_addr, 32'h30);
    chk("ho_wdata_n2", rr_mem_wdata, 32'hC0FFEE00);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
    sb_q.push_back({1'b1, ref_mem[8'h30]});
    @(negedge clk);
    chk("ho_m1_rd_gnt", 32'(rr_m1_gnt), 32'd1);
    tick();
    drive(1'b1, 1'b1, 32'h40, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("drop_m0_gnt_wait", 32'(rr_m0_gnt), 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("drop_no_strobe", 32'({rr_m0_gnt, rr_mem_write, rr_mem_read}), 32'd0);
    chk("drop_cnt", 32'(rr_cnt), 32'd0);
    tick();
    tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
